// File: rtl/sr_config_ctrl.sv
// Serial configuration master: shifts a latched word into an on-chip SR chain, then strobes sr_load.
// Optional readback capture of sr_dout is enabled by defining SR_READBACK_EN.
`timescale 1ns/1ps
module sr_config_ctrl #(
  parameter int DATA_WIDTH  = 170,
  parameter int CNT_WIDTH   = 8,
  parameter int CLK_DIV     = 2,
  parameter int LOAD_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  msb_first,
  output logic                  busy,
  output logic                  done,
  output logic                  sr_din,
  output logic                  sr_clk,
  output logic                  sr_load,
  input  logic                  sr_dout,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rb_valid,
  output logic                  rb_mismatch
);
  localparam int DIV_MAX = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_LOAD, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  msb_q, msb_d;
  logic                  busy_q, done_q, sr_din_q, sr_clk_q, sr_load_q;
  logic [CNT_WIDTH-1:0]  idx_d;
  logic [DATA_WIDTH-1:0] shifted_d;
  logic                  bit_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    msb_d   = msb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d  = din;
          msb_d   = msb_first;
          cnt_d   = '0;
          div_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        div_d   = '0;
        state_d = S_LOW;
      end
      S_LOW: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          state_d = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d   = '0;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1)) ? S_LOAD : S_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (div_q == DIV_W'(LOAD_CYCLES - 1)) begin
          div_d   = '0;
          state_d = S_DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values, so the bit for the coming cycle is chosen here.
    idx_d     = msb_d ? (CNT_WIDTH'(DATA_WIDTH - 1) - cnt_d) : cnt_d;
    shifted_d = word_d >> idx_d;
    bit_d     = (state_d inside {S_SETUP, S_LOW, S_HIGH}) ? shifted_d[0] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      msb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sr_din_q  <= 1'b0;
      sr_clk_q  <= 1'b0;
      sr_load_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      msb_q     <= msb_d;
      busy_q    <= state_d inside {S_SETUP, S_LOW, S_HIGH, S_LOAD};
      done_q    <= (state_d == S_DONE);
      sr_din_q  <= bit_d;
      sr_clk_q  <= (state_d == S_HIGH);
      sr_load_q <= (state_d == S_LOAD);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sr_din  = sr_din_q;
  assign sr_clk  = sr_clk_q;
  assign sr_load = sr_load_q;

`ifdef SR_READBACK_EN
  logic [DATA_WIDTH-1:0] cap_q, last_q, rdata_q, cap_mask;
  logic [CNT_WIDTH-1:0]  idx_q;
  logic                  rb_valid_q, rb_mis_q;

  assign idx_q    = msb_q ? (CNT_WIDTH'(DATA_WIDTH - 1) - cnt_q) : cnt_q;
  assign cap_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q      <= '0;
      last_q     <= '0;
      rdata_q    <= '0;
      rb_valid_q <= 1'b0;
      rb_mis_q   <= 1'b0;
    end else begin
      rb_valid_q <= 1'b0;
      // Chip presents its old bit while sr_clk is high; take it in the first high cycle.
      if (state_q == S_HIGH && div_q == '0)
        cap_q <= sr_dout ? (cap_q | cap_mask) : (cap_q & ~cap_mask);
      if (state_d == S_DONE) begin
        rdata_q    <= cap_q;
        rb_mis_q   <= (cap_q != last_q);
        last_q     <= word_q;
        rb_valid_q <= 1'b1;
      end
    end
  end

  assign rdata       = rdata_q;
  assign rb_valid    = rb_valid_q;
  assign rb_mismatch = rb_mis_q;
`else
  logic unused_sr_dout;
  assign unused_sr_dout = sr_dout;
  assign rdata          = '0;
  assign rb_valid       = 1'b0;
  assign rb_mismatch    = 1'b0;
`endif
endmodule

// File: tb/tb_sr_config_ctrl.sv
// Scoreboard bench for sr_config_ctrl: stimulus queues expected transfers, a monitor checks each done.
// Define SR_READBACK_EN for both files to exercise the readback path with an 8-bit chip model.
`timescale 1ns/1ps
module tb_sr_config_ctrl;
  localparam int DW = 8;
  localparam int CW = 4;
  localparam int CD = 2;
  localparam int LC = 2;
  localparam int LATENCY = 36;   // 1 + 1 + 2*2*8 + 2
  localparam int BUSY_CYCLES = 35;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] din = '0;
  logic          msb_first = 1'b0;
  logic          sr_dout;
  logic          busy, done, sr_din, sr_clk, sr_load, rb_valid, rb_mismatch;
  logic [DW-1:0] rdata;

  always #5 clk = ~clk;

  sr_config_ctrl #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .CLK_DIV(CD), .LOAD_CYCLES(LC)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .msb_first(msb_first),
    .busy(busy), .done(done), .sr_din(sr_din), .sr_clk(sr_clk), .sr_load(sr_load),
    .sr_dout(sr_dout), .rdata(rdata), .rb_valid(rb_valid), .rb_mismatch(rb_mismatch)
  );

  typedef struct {
    logic [7:0] seq;
    int         done_cyc;
    logic       chk_rb;
    logic [7:0] rdata;
    logic       mis;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SR_READBACK_EN
  logic [7:0] chip = '0;
  logic       chip_dout = 1'b0;
  logic [2:0] pcnt = '0;
  logic       chip_clr = 1'b0;
  logic       stuck3 = 1'b0;
  // FIFO chip: shifted-out bit is held on sr_dout for the whole high phase.
  always @(posedge sr_clk or posedge chip_clr) begin
    if (chip_clr) begin
      chip      <= '0;
      chip_dout <= 1'b0;
      pcnt      <= '0;
    end else begin
      chip_dout <= (stuck3 && pcnt == 3'd3) ? 1'b0 : chip[0];
      chip      <= {sr_din, chip[7:1]};
      pcnt      <= pcnt + 3'd1;
    end
  end
  assign sr_dout = chip_dout;
`else
  always @(negedge clk) sr_dout <= 1'($urandom_range(0, 1));
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Monitor: accumulates per-transfer observations and pops the scoreboard on each done.
  initial begin : monitor
    exp_t       e;
    logic [7:0] seq;
    int         nb, hi_run, badp, load_cnt, busy_cnt;
    logic       prev_clk, hold;
    seq = '0; nb = 0; hi_run = 0; badp = 0; load_cnt = 0; busy_cnt = 0;
    prev_clk = 1'b0; hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seq = '0; nb = 0; hi_run = 0; badp = 0; load_cnt = 0; busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (sr_load) load_cnt++;
        if (sr_clk) begin
          if (!prev_clk) begin
            if (nb < 8) seq[nb] = sr_din;
            nb++;
            hold = sr_din;
            hi_run = 1;
          end else begin
            hi_run++;
            if (sr_din !== hold) badp++;
          end
        end else if (prev_clk && hi_run != CD) begin
          badp++;
        end
        if (done) begin
          n_done++;
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no done", cyc);
          end else begin
            e = sbq.pop_front();
            $display("xfer done at cycle %0d: serial bits %02h", cyc, seq);
            check("serial_bits", 32'(seq), 32'(e.seq));
            check("sr_clk_pulses", nb, 8);
            check("pulse_shape_errors", badp, 0);
            check("load_cycles", load_cnt, LC);
            check("busy_cycles", busy_cnt, BUSY_CYCLES);
            check("done_cycle", cyc, e.done_cyc);
            check("done_busy_low", 32'(busy), 0);
`ifdef SR_READBACK_EN
            check("rb_valid", 32'(rb_valid), 1);
            if (e.chk_rb) begin
              check("rdata", 32'(rdata), 32'(e.rdata));
              check("rb_mismatch", 32'(rb_mismatch), 32'(e.mis));
            end
`else
            check("rdata_tied", 32'(rdata), 0);
            check("rb_valid_tied", 32'(rb_valid), 0);
            check("rb_mismatch_tied", 32'(rb_mismatch), 0);
`endif
          end
          seq = '0; nb = 0; badp = 0; load_cnt = 0; busy_cnt = 0;
        end
      end
      prev_clk = sr_clk;
    end
  end

  task automatic xfer(input logic [7:0] d, input logic m, input logic [7:0] seq,
                      input logic chk, input logic [7:0] rd, input logic mis);
    exp_t e;
    @(negedge clk);
    din = d; msb_first = m; start = 1'b1;
    e.seq = seq; e.done_cyc = cyc + LATENCY; e.chk_rb = chk; e.rdata = rd; e.mis = mis;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0; din = ~d; msb_first = ~m;
  endtask

  task automatic wait_done(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    n_chk++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", budget);
    end
  endtask

  initial begin : stim
    int rises, k, dones_before;
    logic p;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sr_clk", 32'(sr_clk), 0);
    check("rst_sr_load", 32'(sr_load), 0);
    check("rst_sr_din", 32'(sr_din), 0);
    check("rst_rdata", 32'(rdata), 0);
    rst = 1'b0;

    xfer(8'hA5, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0); wait_done(100);
    xfer(8'hA5, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0); wait_done(100);
    xfer(8'h01, 1'b1, 8'h80, 1'b0, 8'h00, 1'b0); wait_done(100);
    xfer(8'h01, 1'b0, 8'h01, 1'b0, 8'h00, 1'b0); wait_done(100);

    // Extra starts while busy must be ignored; then a back-to-back start right after done.
    xfer(8'hC3, 1'b0, 8'hC3, 1'b0, 8'h00, 1'b0);
    repeat (10) begin
      @(negedge clk); start = 1'b1; din = 8'h00;
      @(negedge clk); start = 1'b0;
    end
    wait_done(100);
    xfer(8'h96, 1'b1, 8'h69, 1'b0, 8'h00, 1'b0); wait_done(100);
    repeat (60) @(negedge clk);
    check("done_count_after_b2b", n_done, 6);

    // Abort at the 4th sr_clk high; bit 3 of 8'h08 is the one on sr_din then.
    xfer(8'h08, 1'b0, 8'h08, 1'b0, 8'h00, 1'b0);
    rises = 0; p = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (sr_clk && !p) rises++;
      p = sr_clk;
      if (rises == 4) break;
    end
    check("abort_reached_4th_high", rises, 4);
    check("pre_abort_sr_clk", 32'(sr_clk), 1);
    check("pre_abort_sr_din", 32'(sr_din), 1);
    dones_before = n_done;
    rst = 1'b1;
    sbq.delete();
    #1;
    check("abort_sr_clk", 32'(sr_clk), 0);
    check("abort_sr_load", 32'(sr_load), 0);
    check("abort_sr_din", 32'(sr_din), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("no_done_after_abort", n_done, dones_before);

    xfer(8'h3C, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0); wait_done(100);

`ifdef SR_READBACK_EN
    @(negedge clk); rst = 1'b1; chip_clr = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0; chip_clr = 1'b0;
    xfer(8'h5A, 1'b0, 8'h5A, 1'b1, 8'h00, 1'b0); wait_done(100);
    xfer(8'h5A, 1'b0, 8'h5A, 1'b1, 8'h5A, 1'b0); wait_done(100);
    stuck3 = 1'b1;
    xfer(8'hFF, 1'b0, 8'hFF, 1'b1, 8'h52, 1'b1); wait_done(100);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
